nibbler_core_p: RTL and testbench
=================================

# nibbler_core_p

Parametrised successor of the 4-bit Nibbler microprocessor core: an accumulator machine with a generic data width. It runs a two-phase fetch/execute sequence and adds a ready handshake on program memory, so slow ROMs insert wait states. Program ROM, data RAM and the top-level pushbutton/LED wiring stay outside the block. Default parameters reproduce the existing 4-bit / 12-bit-address machine.

## Interface
- DATA_W, 4: accumulator, operand, RAM data and I/O port width (≥2).
- Derived, not overridable: PROG_W = 4+DATA_W (program word = opcode[PROG_W-1:DATA_W] + operand[DATA_W-1:0]); ADDR_W = DATA_W+PROG_W (12 at default).

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- prog_addr  out  ADDR_W  program address; equals pc in FETCH, pc+1 in FETCH2
- prog_data  in  PROG_W  program word
- prog_ready  in  1  prog_data valid for prog_addr this cycle
- data_addr  out  ADDR_W  RAM address {operand, second word}
- data_wdata  out  DATA_W  equals accu
- data_rdata  in  DATA_W  RAM read data, combinational from data_addr
- data_we  out  1  one-cycle write strobe
- in_port  in  DATA_W  pushbutton input
- out_port  out  DATA_W  output register (FF_out)
- accu  out  DATA_W  accumulator
- c_flag, z_flag  out  1 each  carry / zero flags
- pc  out  ADDR_W  program counter
- phase  out  2  state: 0 FETCH, 1 FETCH2, 2 EXEC

## Operation
- Reset (asynchronous, reset=0): pc=0, accu=0, c_flag=0, z_flag=0, out_port=0, phase=FETCH, data_we=0, internal instruction register=0.
- FETCH: prog_addr=pc, held until prog_ready=1. On that edge, latch opcode/operand. Two-word opcodes (JC, JNC, CMPM, LD, ST, JZ, JNZ, ADDM, JMP, NORM) go to FETCH2; all others go to EXEC.
- FETCH2: prog_addr=pc+1, waits on prog_ready the same way. Latches the low PROG_W address bits, then goes to EXEC.
- EXEC: always exactly 1 cycle, then FETCH. pc advances by 1 (one-word) or 2 (two-word) unless a jump is taken. A taken jump loads pc={operand, word2}.
- pc arithmetic is modulo 2^ADDR_W (wraps to 0).
- Opcodes:
  - 0 JC: jump if c=1. 1 JNC: jump if c=0. 8 JZ: jump if z=1. 9 JNZ: jump if z=0. C JMP: unconditional.
  - 2 CMPI k and 3 CMPM m: flags from accu−x; c = (accu ≥ x); z = (accu == x); accu unchanged.
  - 4 LIT k: accu=k. 5 IN: accu=in_port. 6 LD m: accu=data_rdata.
  - 7 ST m: data_we=1 for the EXEC cycle only.
  - A ADDI k and B ADDM m: {c,accu} = accu+x, DATA_W+1-bit sum; z = (result==0).
  - D OUT: out_port=accu.
  - E NORI k and F NORM m: accu = ~(accu|x); z updated; c unchanged.
- Flag updates by opcode:
  - LIT, IN, LD: update z only.
  - Jumps, ST, OUT: leave both flags unchanged.
- data_addr is valid in EXEC. Its value outside EXEC is don't-care, but data_we=0 there.
- Reset asserted mid-instruction aborts it immediately. No partial RAM write survives: data_we drops asynchronously.

## Timing
- Two-phase control: a one-word instruction takes 2 cycles and a two-word instruction takes 3, with prog_ready held high. Each low cycle of prog_ready adds exactly one cycle to the current FETCH/FETCH2.
- Registers (accu, flags, out_port, pc) update on the rising edge ending EXEC. They are visible from the next cycle.
- A conditional jump samples the flags as they stood at the start of EXEC. A flag update from the previous instruction is therefore seen.
- First fetch after reset release: prog_addr=0 in the first cycle with reset=1.

## Test plan
- Reset, DATA_W=4, prog_ready=1, program LIT 5; ADDI 0xC. Required: accu=0x1, c=1, z=0 after cycle 4; pc=2.
- in_port=4'b1111, program IN; OUT; NORI 0. Required: out_port=0xF after cycle 4; accu=0x0, z=1 after cycle 6.
- Program ST 0x3A5, LIT 0, LD 0x3A5, starting from accu=0x9. Required: data_we high for exactly 1 cycle with data_addr=0x3A5 and data_wdata=0x9; accu=0x9 after LD. LD takes 3 cycles.
- CMPI 7 with accu=7, then JZ 0x123. Required: z=1, c=1, pc=0x123. A JNZ in the same place instead falls through to pc+2.
- prog_ready low for 3 cycles during FETCH and 2 during FETCH2 of JMP 0xFFF, then NOP-equivalent LIT at 0xFFF. Required: JMP completes in 8 cycles; after LIT, pc wraps to 0x000.
- Assert reset during EXEC of ST. Required: data_we falls immediately; all outputs return to reset values; phase=FETCH, prog_addr=0 when reset is released.
- Repeat the add and compare scenarios with DATA_W=8. Required: ADDI 0x01 with accu=0xFF gives accu=0x00, c=1, z=1; ADDR_W=20.

Source files
------------

// File: rtl/nibbler_core_p_if.sv
// Program-ROM and data-RAM bus of the nibbler core.
// The core drives the master side; memories (or a bench) sit on the slave side.
// DATA_W here must match the DATA_W of the core it connects to.
interface nibbler_core_p_if #(
  parameter int DATA_W = 4
);
  localparam int PROG_W = 4 + DATA_W;
  localparam int ADDR_W = DATA_W + PROG_W;

  logic [ADDR_W-1:0] prog_addr;
  logic [PROG_W-1:0] prog_data;
  logic              prog_ready;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_we;

  modport master (
    output prog_addr,
    input  prog_data,
    input  prog_ready,
    output data_addr,
    output data_wdata,
    input  data_rdata,
    output data_we
  );

  modport slave (
    input  prog_addr,
    output prog_data,
    output prog_ready,
    input  data_addr,
    input  data_wdata,
    output data_rdata,
    input  data_we
  );
endinterface

// File: rtl/nibbler_core_p.sv
// Parametrised nibbler accumulator core: FETCH / FETCH2 / EXEC sequencing with
// wait states on program memory, one-cycle execute, asynchronous active-low reset.
module nibbler_core_p #(
  parameter  int DATA_W = 4,
  localparam int PROG_W = 4 + DATA_W,
  localparam int ADDR_W = DATA_W + PROG_W
) (
  input  logic              clock,
  input  logic              reset,
  nibbler_core_p_if.master  bus,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] accu,
  output logic              c_flag,
  output logic              z_flag,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        phase
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FETCH2 = 2'd1,
    EXEC   = 2'd2
  } phase_t;

  localparam logic [3:0] OP_JC   = 4'h0, OP_JNC  = 4'h1, OP_CMPI = 4'h2, OP_CMPM = 4'h3;
  localparam logic [3:0] OP_LIT  = 4'h4, OP_IN   = 4'h5, OP_LD   = 4'h6, OP_ST   = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8, OP_JNZ  = 4'h9, OP_ADDI = 4'hA, OP_ADDM = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC, OP_OUT  = 4'hD, OP_NORI = 4'hE, OP_NORM = 4'hF;

  // Two-word opcodes carry a full address; every one of them that reads data
  // takes its operand from RAM, so this also selects the RAM operand path.
  function automatic logic is_two_word(input logic [3:0] op);
    case (op)
      OP_JC, OP_JNC, OP_CMPM, OP_LD, OP_ST, OP_JZ,
      OP_JNZ, OP_ADDM, OP_JMP, OP_NORM: is_two_word = 1'b1;
      default:                          is_two_word = 1'b0;
    endcase
  endfunction

  phase_t            phase_reg, phase_next;
  logic [3:0]        opcode_reg;
  logic [DATA_W-1:0] operand_reg;
  logic [PROG_W-1:0] word2_reg;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] accu_reg, accu_next;
  logic [DATA_W-1:0] out_reg, out_next;
  logic              c_reg, c_next, z_reg, z_next;

  logic              two_word;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] x_val;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] nor_w;

  assign two_word = is_two_word(opcode_reg);
  assign target   = {operand_reg, word2_reg};
  assign x_val    = two_word ? bus.data_rdata : operand_reg;
  assign sum_w    = {1'b0, accu_reg} + {1'b0, x_val};
  assign nor_w    = ~(accu_reg | x_val);

  // Phase register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) phase_reg <= FETCH;
    else        phase_reg <= phase_next;
  end

  // Next phase: fetch phases stall until prog_ready, EXEC is always one cycle.
  always_comb begin
    phase_next = phase_reg;
    case (phase_reg)
      FETCH: begin
        if (bus.prog_ready)
          phase_next = is_two_word(bus.prog_data[PROG_W-1:DATA_W]) ? FETCH2 : EXEC;
      end
      FETCH2:  if (bus.prog_ready) phase_next = EXEC;
      EXEC:    phase_next = FETCH;
      default: phase_next = FETCH;
    endcase
  end

  // Bus outputs decoded from phase; data_we follows the async-reset phase so it drops with reset.
  always_comb begin
    bus.prog_addr  = (phase_reg == FETCH2) ? pc_reg + ADDR_W'(1) : pc_reg;
    bus.data_addr  = target;
    bus.data_wdata = accu_reg;
    bus.data_we    = (phase_reg == EXEC) && (opcode_reg == OP_ST);
  end

  // Instruction register: opcode/operand from the first word, low address bits from the second.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opcode_reg  <= '0;
      operand_reg <= '0;
      word2_reg   <= '0;
    end else if (bus.prog_ready) begin
      if (phase_reg == FETCH) begin
        opcode_reg  <= bus.prog_data[PROG_W-1:DATA_W];
        operand_reg <= bus.prog_data[DATA_W-1:0];
      end else if (phase_reg == FETCH2) begin
        word2_reg   <= bus.prog_data;
      end
    end
  end

  // Execute: architectural next state; jumps sample the flags as they stand now.
  always_comb begin
    accu_next = accu_reg;
    out_next  = out_reg;
    c_next    = c_reg;
    z_next    = z_reg;
    pc_next   = pc_reg + {{(ADDR_W-2){1'b0}}, two_word, ~two_word};
    case (opcode_reg)
      OP_JC:           if (c_reg)  pc_next = target;
      OP_JNC:          if (!c_reg) pc_next = target;
      OP_JZ:           if (z_reg)  pc_next = target;
      OP_JNZ:          if (!z_reg) pc_next = target;
      OP_JMP:          pc_next = target;
      OP_CMPI, OP_CMPM: begin
        c_next = (accu_reg >= x_val);
        z_next = (accu_reg == x_val);
      end
      OP_LIT: begin
        accu_next = operand_reg;
        z_next    = (operand_reg == '0);
      end
      OP_IN: begin
        accu_next = in_port;
        z_next    = (in_port == '0);
      end
      OP_LD: begin
        accu_next = bus.data_rdata;
        z_next    = (bus.data_rdata == '0);
      end
      OP_ADDI, OP_ADDM: begin
        {c_next, accu_next} = sum_w;
        z_next = (sum_w[DATA_W-1:0] == '0);
      end
      OP_OUT:          out_next = accu_reg;
      OP_NORI, OP_NORM: begin
        accu_next = nor_w;
        z_next    = (nor_w == '0);
      end
      default: ;
    endcase
  end

  // Architectural registers commit on the edge that ends EXEC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg   <= '0;
      accu_reg <= '0;
      out_reg  <= '0;
      c_reg    <= 1'b0;
      z_reg    <= 1'b0;
    end else if (phase_reg == EXEC) begin
      pc_reg   <= pc_next;
      accu_reg <= accu_next;
      out_reg  <= out_next;
      c_reg    <= c_next;
      z_reg    <= z_next;
    end
  end

  assign pc       = pc_reg;
  assign accu     = accu_reg;
  assign out_port = out_reg;
  assign c_flag   = c_reg;
  assign z_flag   = z_reg;
  assign phase    = phase_reg;

endmodule

// File: tb/tb_nibbler_core_p.sv
// Directed bench for nibbler_core_p: default 4-bit core plus an 8-bit instance.
module tb_nibbler_core_p;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // ---------------- 4-bit instance ----------------
  nibbler_core_p_if #(.DATA_W(4)) bus ();
  logic [3:0]  in_port = 4'h0;
  logic [3:0]  out_port, accu;
  logic        c_flag, z_flag;
  logic [11:0] pc;
  logic [1:0]  phase;

  nibbler_core_p #(.DATA_W(4)) dut (
    .clock(clock), .reset(reset), .bus(bus.master), .in_port(in_port),
    .out_port(out_port), .accu(accu), .c_flag(c_flag), .z_flag(z_flag),
    .pc(pc), .phase(phase)
  );

  logic [7:0]  rom [0:4095];
  logic [3:0]  ram [0:4095];
  logic        ram_load = 1'b0;
  logic [11:0] ram_load_addr = '0;
  logic [3:0]  ram_load_data = '0;

  assign bus.prog_data  = rom[bus.prog_addr];
  assign bus.data_rdata = ram[bus.data_addr];

  always @(posedge clock) begin
    if (bus.data_we)   ram[bus.data_addr] <= bus.data_wdata;
    else if (ram_load) ram[ram_load_addr] <= ram_load_data;
  end

  // ---------------- 8-bit instance ----------------
  nibbler_core_p_if #(.DATA_W(8)) bus8 ();
  logic [7:0]  in_port8 = 8'h00;
  logic [7:0]  out_port8, accu8;
  logic        c8, z8;
  logic [19:0] pc8;
  logic [1:0]  phase8;
  logic [11:0] rom8 [0:15];

  nibbler_core_p #(.DATA_W(8)) dut8 (
    .clock(clock), .reset(reset), .bus(bus8.master), .in_port(in_port8),
    .out_port(out_port8), .accu(accu8), .c_flag(c8), .z_flag(z8),
    .pc(pc8), .phase(phase8)
  );

  assign bus8.prog_data  = rom8[bus8.prog_addr[3:0]];
  assign bus8.data_rdata = 8'h00;
  assign bus8.prog_ready = 1'b1;

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold reset, fill ROM with LIT 0, enable ready.
  task automatic hold_reset();
    reset = 1'b0;
    bus.prog_ready = 1'b1;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h40;
    for (int i = 0; i < 16; i++) rom8[i] = 12'h400;
    tick();
  endtask

  task automatic ram_poke(input logic [11:0] a, input logic [3:0] d);
    ram_load_addr = a;
    ram_load_data = d;
    ram_load = 1'b1;
    tick();
    ram_load = 1'b0;
  endtask

  // Release at a falling edge; returns #1 into cycle 1.
  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    bus.prog_ready = 1'b1;
    tick();
    if (accu !== 4'h0)    begin fails++; $display("FAIL reset_accu: got %h expected 0", accu); end
    tests++;
    if (pc !== 12'h000)   begin fails++; $display("FAIL reset_pc: got %h expected 000", pc); end
    tests++;
    if (phase !== 2'd0)   begin fails++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    tests++;
    if (out_port !== 4'h0) begin fails++; $display("FAIL reset_out: got %h expected 0", out_port); end
    tests++;
    if ({c_flag, z_flag} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b expected 00", {c_flag, z_flag}); end
    tests++;
    if (bus.data_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", bus.data_we); end
    tests++;
    $display("[TB] test_reset done");
  endtask

  task automatic test_add();
    hold_reset();
    rom[0] = 8'h45;  // LIT 5
    rom[1] = 8'hAC;  // ADDI C
    release_reset();
    repeat (4) tick();
    if (accu !== 4'h1)   begin fails++; $display("FAIL add_accu: got %h expected 1", accu); end
    tests++;
    if (c_flag !== 1'b1) begin fails++; $display("FAIL add_c: got %b expected 1", c_flag); end
    tests++;
    if (z_flag !== 1'b0) begin fails++; $display("FAIL add_z: got %b expected 0", z_flag); end
    tests++;
    if (pc !== 12'h002)  begin fails++; $display("FAIL add_pc: got %h expected 002", pc); end
    tests++;
    $display("[TB] test_add done");
  endtask

  task automatic test_io();
    hold_reset();
    in_port = 4'hF;
    rom[0] = 8'h50;  // IN
    rom[1] = 8'hD0;  // OUT
    rom[2] = 8'hE0;  // NORI 0
    release_reset();
    repeat (4) tick();
    if (out_port !== 4'hF) begin fails++; $display("FAIL io_out: got %h expected F", out_port); end
    tests++;
    repeat (2) tick();
    if (accu !== 4'h0)   begin fails++; $display("FAIL io_nor_accu: got %h expected 0", accu); end
    tests++;
    if (z_flag !== 1'b1) begin fails++; $display("FAIL io_nor_z: got %b expected 1", z_flag); end
    tests++;
    in_port = 4'h0;
    $display("[TB] test_io done");
  endtask

  task automatic test_store_load();
    int we_cnt = 0;
    int we_cyc = 0;
    logic [11:0] we_addr = '0;
    logic [3:0]  we_data = '0;
    hold_reset();
    ram_poke(12'h3A5, 4'h0);
    rom[0] = 8'h49;                  // LIT 9
    rom[1] = 8'h73; rom[2] = 8'hA5;  // ST 3A5
    rom[3] = 8'h40;                  // LIT 0
    rom[4] = 8'h63; rom[5] = 8'hA5;  // LD 3A5
    release_reset();
    for (int k = 1; k <= 10; k++) begin
      if (bus.data_we === 1'b1) begin
        we_cnt++;
        we_cyc  = k;
        we_addr = bus.data_addr;
        we_data = bus.data_wdata;
      end
      if (k == 10 && accu !== 4'h0) begin fails++; $display("FAIL ld_latency: got %h expected 0 before LD ends", accu); end
      if (k == 10) tests++;
      tick();
    end
    if (we_cnt !== 1 || we_cyc !== 5) begin fails++; $display("FAIL st_strobe: got %0d pulses at cycle %0d expected 1 at cycle 5", we_cnt, we_cyc); end
    tests++;
    if (we_addr !== 12'h3A5) begin fails++; $display("FAIL st_addr: got %h expected 3A5", we_addr); end
    tests++;
    if (we_data !== 4'h9) begin fails++; $display("FAIL st_wdata: got %h expected 9", we_data); end
    tests++;
    if (ram[12'h3A5] !== 4'h9) begin fails++; $display("FAIL st_ram: got %h expected 9", ram[12'h3A5]); end
    tests++;
    if (accu !== 4'h9) begin fails++; $display("FAIL ld_accu: got %h expected 9", accu); end
    tests++;
    if (pc !== 12'h006) begin fails++; $display("FAIL ld_pc: got %h expected 006", pc); end
    tests++;
    $display("[TB] test_store_load done");
  endtask

  task automatic test_mem_ops();
    hold_reset();
    ram_poke(12'h010, 4'h3);
    rom[0] = 8'h46;                  // LIT 6
    rom[1] = 8'hB0; rom[2] = 8'h10;  // ADDM 010 -> 9
    rom[3] = 8'h30; rom[4] = 8'h10;  // CMPM 010 -> c=1 z=0
    rom[5] = 8'hF0; rom[6] = 8'h10;  // NORM 010 -> ~(9|3)=4
    release_reset();
    repeat (5) tick();
    if ({c_flag, accu} !== 5'h09) begin fails++; $display("FAIL addm: got c=%b accu=%h expected c=0 accu=9", c_flag, accu); end
    tests++;
    repeat (6) tick();
    if (accu !== 4'h4)   begin fails++; $display("FAIL norm_accu: got %h expected 4", accu); end
    tests++;
    if ({c_flag, z_flag} !== 2'b10) begin fails++; $display("FAIL cmpm_norm_flags: got %b expected 10", {c_flag, z_flag}); end
    tests++;
    if (pc !== 12'h007)  begin fails++; $display("FAIL memops_pc: got %h expected 007", pc); end
    tests++;
    $display("[TB] test_mem_ops done");
  endtask

  task automatic test_jumps();
    logic [7:0]  cmp_w, jmp_w;
    logic [11:0] exp_pc;
    logic [1:0]  exp_cz;
    for (int v = 0; v < 4; v++) begin
      case (v)
        0:       begin cmp_w = 8'h27; jmp_w = 8'h81; exp_pc = 12'h123; exp_cz = 2'b11; end  // CMPI 7; JZ
        1:       begin cmp_w = 8'h27; jmp_w = 8'h91; exp_pc = 12'h004; exp_cz = 2'b11; end  // CMPI 7; JNZ
        2:       begin cmp_w = 8'h29; jmp_w = 8'h01; exp_pc = 12'h004; exp_cz = 2'b00; end  // CMPI 9; JC
        default: begin cmp_w = 8'h29; jmp_w = 8'h11; exp_pc = 12'h123; exp_cz = 2'b00; end  // CMPI 9; JNC
      endcase
      hold_reset();
      rom[0] = 8'h47;
      rom[1] = cmp_w;
      rom[2] = jmp_w;
      rom[3] = 8'h23;
      release_reset();
      repeat (7) tick();
      if (pc !== exp_pc) begin fails++; $display("FAIL jump_pc[%0d]: got %h expected %h", v, pc, exp_pc); end
      tests++;
      if ({c_flag, z_flag} !== exp_cz) begin fails++; $display("FAIL jump_flags[%0d]: got %b expected %b", v, {c_flag, z_flag}, exp_cz); end
      tests++;
      if (accu !== 4'h7) begin fails++; $display("FAIL cmp_accu[%0d]: got %h expected 7", v, accu); end
      tests++;
      $display("[TB] test_jumps variant %0d done", v);
    end
  endtask

  task automatic test_wait_states();
    hold_reset();
    rom[0] = 8'hCF; rom[1] = 8'hFF;  // JMP FFF
    rom[12'hFFF] = 8'h42;            // LIT 2
    release_reset();
    for (int k = 1; k <= 10; k++) begin
      bus.prog_ready = !((k >= 1 && k <= 3) || k == 5 || k == 6);
      if (k == 4 && phase !== 2'd0) begin fails++; $display("FAIL wait_fetch_hold: got phase %0d expected 0", phase); end
      if (k == 4) tests++;
      if (k == 5 && (phase !== 2'd1 || bus.prog_addr !== 12'h001)) begin fails++; $display("FAIL wait_fetch2: got phase %0d addr %h expected 1/001", phase, bus.prog_addr); end
      if (k == 5) tests++;
      if (k == 7 && phase !== 2'd1) begin fails++; $display("FAIL wait_fetch2_hold: got phase %0d expected 1", phase); end
      if (k == 7) tests++;
      if (k == 8 && phase !== 2'd2) begin fails++; $display("FAIL wait_exec_cycle: got phase %0d expected 2", phase); end
      if (k == 8) tests++;
      if (k == 9 && (pc !== 12'hFFF || bus.prog_addr !== 12'hFFF)) begin fails++; $display("FAIL wait_jmp_pc: got pc %h addr %h expected FFF", pc, bus.prog_addr); end
      if (k == 9) tests++;
      tick();
    end
    if (pc !== 12'h000) begin fails++; $display("FAIL pc_wrap: got %h expected 000", pc); end
    tests++;
    if (accu !== 4'h2)  begin fails++; $display("FAIL wrap_lit: got %h expected 2", accu); end
    tests++;
    bus.prog_ready = 1'b1;
    $display("[TB] test_wait_states done");
  endtask

  task automatic test_abort();
    hold_reset();
    ram_poke(12'h3A5, 4'h0);
    rom[0] = 8'h49;                  // LIT 9
    rom[1] = 8'hD0;                  // OUT
    rom[2] = 8'h73; rom[3] = 8'hA5;  // ST 3A5
    release_reset();
    repeat (6) tick();
    if (phase !== 2'd2 || bus.data_we !== 1'b1) begin fails++; $display("FAIL abort_pre: got phase %0d we %b expected 2/1", phase, bus.data_we); end
    tests++;
    #2;
    reset = 1'b0;
    #1;
    if (bus.data_we !== 1'b0) begin fails++; $display("FAIL abort_we: got %b expected 0", bus.data_we); end
    tests++;
    if ({accu, out_port} !== 8'h00) begin fails++; $display("FAIL abort_regs: got accu %h out %h expected 0/0", accu, out_port); end
    tests++;
    if (pc !== 12'h000 || phase !== 2'd0) begin fails++; $display("FAIL abort_pc_phase: got pc %h phase %0d expected 000/0", pc, phase); end
    tests++;
    repeat (2) tick();
    if (ram[12'h3A5] !== 4'h0) begin fails++; $display("FAIL abort_ram: got %h expected 0", ram[12'h3A5]); end
    tests++;
    release_reset();
    if (phase !== 2'd0 || bus.prog_addr !== 12'h000) begin fails++; $display("FAIL abort_restart: got phase %0d addr %h expected 0/000", phase, bus.prog_addr); end
    tests++;
    $display("[TB] test_abort done");
  endtask

  task automatic test_width8();
    hold_reset();
    rom8[0] = 12'h4FF;  // LIT FF
    rom8[1] = 12'hA01;  // ADDI 01
    rom8[2] = 12'h200;  // CMPI 00
    rom8[3] = 12'h201;  // CMPI 01
    rom8[4] = 12'hCAB;  // JMP ABCDE
    rom8[5] = 12'hCDE;
    release_reset();
    repeat (4) tick();
    if (accu8 !== 8'h00) begin fails++; $display("FAIL w8_add_accu: got %h expected 00", accu8); end
    tests++;
    if ({c8, z8} !== 2'b11) begin fails++; $display("FAIL w8_add_flags: got %b expected 11", {c8, z8}); end
    tests++;
    if (pc8 !== 20'h00002) begin fails++; $display("FAIL w8_pc: got %h expected 00002", pc8); end
    tests++;
    repeat (2) tick();
    if ({c8, z8} !== 2'b11) begin fails++; $display("FAIL w8_cmp_eq: got %b expected 11", {c8, z8}); end
    tests++;
    repeat (2) tick();
    if ({c8, z8} !== 2'b00) begin fails++; $display("FAIL w8_cmp_lt: got %b expected 00", {c8, z8}); end
    tests++;
    repeat (3) tick();
    if (pc8 !== 20'hABCDE) begin fails++; $display("FAIL w8_jmp_addr20: got %h expected ABCDE", pc8); end
    tests++;
    $display("[TB] test_width8 done");
  endtask

  initial begin
    bus.prog_ready = 1'b1;
    test_reset();
    test_add();
    test_io();
    test_store_load();
    test_mem_ops();
    test_jumps();
    test_wait_states();
    test_abort();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
